// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data RAM plus MMIO page (GPIO, cycle counter, UART TX)
// on the memory-stage port; reads are combinational, writes land on the edge.
module dmem_mmio_responder #(
  parameter int DEPTH   = 256,
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        uart_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          sel_ram;
  logic          sel_io;
  logic          gpio_wr;
  logic          tx_wr;

  logic [31:0]   cycle;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          busy;
  logic          cnt_end;

  assign idx     = mem_addr[AW+1:2];
  assign off     = mem_addr[3:2];
  assign sel_ram = (mem_addr[31:28] == 4'h0);
  assign sel_io  = (mem_addr[31:28] == 4'h1);
  assign gpio_wr = sel_io && mem_we && (off == 2'd0);
  assign tx_wr   = sel_io && mem_we && (off == 2'd2);
  assign busy    = (state != IDLE);
  assign cnt_end = (cnt == CNT_LAST);

  // Word RAM: contents survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (sel_ram && mem_we) begin
      ram[idx] <= mem_wdata;
    end
  end

  // GPIO register and free-running cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
      cycle    <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (gpio_wr) begin
        gpio_out <= mem_wdata;
      end
    end
  end

  // UART state, baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  // UART next state and line level; counter clears on any state/bit change.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    uart_tx = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_wr) begin
          state_n = START;
          shift_n = mem_wdata[7:0];
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (cnt_end) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        uart_tx = shift[0];
        if (cnt_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Read mux: zero for the TX register and for unmapped regions.
  always_comb begin
    mem_rdata = '0;
    unique case (1'b1)
      sel_ram: mem_rdata = ram[idx];
      sel_io: begin
        unique case (off)
          2'd0:    mem_rdata = gpio_out;
          2'd1:    mem_rdata = cycle;
          2'd2:    mem_rdata = '0;
          default: mem_rdata = {31'b0, busy};
        endcase
      end
      default: mem_rdata = '0;
    endcase
  end

endmodule
